// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer: FSM states,
// default PC width and the absolute-jump target table.
package pc_pkg;

  localparam int PC_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Entry k is k<<4: jump targets sit on 16-instruction boundaries in the low ROM.
  localparam logic [PC_W_DEF-1:0] JUMP_LUT_C [16] = '{
    12'h000, 12'h010, 12'h020, 12'h030,
    12'h040, 12'h050, 12'h060, 12'h070,
    12'h080, 12'h090, 12'h0A0, 12'h0B0,
    12'h0C0, 12'h0D0, 12'h0E0, 12'h0F0
  };

endpackage

// File: rtl/pc_sequencer_jump_lut.sv
// Absolute-jump target lookup: 4-bit index to PC_W-bit address, purely
// combinational from the package table.
module jump_lut
  import pc_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [3:0]      idx_i,
  output logic [PC_W-1:0] target_o
);

  assign target_o = PC_W'(JUMP_LUT_C[idx_i]);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run control ahead of the instruction ROM: start/restart,
// increment / LUT jump / relative branch, halt or cycle-budget finish.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0]   START_PC   = '0,
  parameter int unsigned       MAX_CYCLES = 'h4000
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              req,
  input  logic              stall,
  input  logic              halt,
  input  logic              jump_en,
  input  logic [3:0]        jump_idx,
  input  logic              br_en,
  input  logic signed [7:0] br_off,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              ack,
  output logic              timeout,
  output logic [15:0]       cycle_cnt
);

  localparam logic [15:0] LAST_CNT = 16'(MAX_CYCLES - 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              ack_q, ack_d;
  logic              tmo_q, tmo_d;

  logic [PC_W-1:0]   jump_tgt;
  logic [PC_W-1:0]   off_ext;
  logic [15:0]       cnt_sat;

  jump_lut #(
    .PC_W (PC_W)
  ) u_jump_lut (
    .idx_i    (jump_idx),
    .target_o (jump_tgt)
  );

  assign off_ext = {{(PC_W-8){br_off[7]}}, br_off};
  assign cnt_sat = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    ack_d   = ack_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          state_d = ST_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
          run_d   = 1'b1;
          ack_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (req) begin
          pc_d  = START_PC;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_sat;
          // Budget check outranks stall and every decoder request.
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            run_d   = 1'b0;
            ack_d   = 1'b1;
            tmo_d   = 1'b1;
          end else if (stall) begin
            pc_d = pc_q;
          end else if (halt) begin
            state_d = ST_DONE;
            run_d   = 1'b0;
            ack_d   = 1'b1;
            tmo_d   = 1'b0;
          end else if (jump_en) begin
            pc_d = jump_tgt;
          end else if (br_en) begin
            pc_d = pc_q + off_ext;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = 1'b0;
        ack_d   = 1'b0;
        tmo_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      ack_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
    end
  end

  assign pc        = pc_q;
  assign running   = run_q;
  assign ack       = ack_q;
  assign timeout   = tmo_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a 16-cycle budget so the timeout path
// is reachable alongside the increment, jump, branch and halt paths.
module tb_pc_sequencer;

  logic              clk;
  logic              init_n;
  logic              req;
  logic              stall;
  logic              halt;
  logic              jump_en;
  logic [3:0]        jump_idx;
  logic              br_en;
  logic signed [7:0] br_off;
  logic [11:0]       pc;
  logic              running;
  logic              ack;
  logic              timeout;
  logic [15:0]       cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(
    .PC_W       (12),
    .START_PC   (12'h000),
    .MAX_CYCLES (16)
  ) dut (
    .clk       (clk),
    .init_n    (init_n),
    .req       (req),
    .stall     (stall),
    .halt      (halt),
    .jump_en   (jump_en),
    .jump_idx  (jump_idx),
    .br_en     (br_en),
    .br_off    (br_off),
    .pc        (pc),
    .running   (running),
    .ack       (ack),
    .timeout   (timeout),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  initial begin
    init_n = 1'b0; req = 1'b0; stall = 1'b0; halt = 1'b0;
    jump_en = 1'b0; jump_idx = 4'd0; br_en = 1'b0; br_off = 8'sd0;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_run", running, 0);
    chk("rst_ack", ack, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_cnt", cycle_cnt, 0);
    init_n = 1'b1;
    tick();
    chk("idle_run", running, 0);

    start();
    chk("start_run", running, 1);
    chk("start_pc", pc, 0);
    chk("start_cnt", cycle_cnt, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("inc_pc", pc, i);
    end
    chk("inc_cnt", cycle_cnt, 5);
    chk("inc_ack", ack, 0);
    chk("inc_run", running, 1);

    tick(); tick();
    chk("pc_7", pc, 12'h007);
    jump_en = 1'b1; jump_idx = 4'd3; br_en = 1'b1; br_off = 8'sh05;
    tick();
    chk("jump_over_br", pc, 12'h030);
    jump_en = 1'b0; br_off = 8'shFC;
    tick();
    chk("br_neg4", pc, 12'h02C);
    chk("cnt_9", cycle_cnt, 9);
    br_en = 1'b0;

    start();
    chk("restart_pc", pc, 0);
    chk("restart_cnt", cycle_cnt, 0);
    chk("restart_run", running, 1);
    br_en = 1'b1; br_off = 8'sh80;
    tick();
    chk("br_m128", pc, 12'hF80);
    br_off = 8'sh7E;
    tick();
    chk("br_to_ffe", pc, 12'hFFE);
    br_off = 8'sh05;
    tick();
    chk("br_wrap", pc, 12'h003);
    br_en = 1'b0;

    start();
    br_en = 1'b1; br_off = 8'sh80;
    tick();
    br_off = 8'sh7F;
    tick();
    chk("br_to_fff", pc, 12'hFFF);
    br_en = 1'b0;
    tick();
    chk("inc_wrap", pc, 12'h000);

    start();
    jump_en = 1'b1; jump_idx = 4'd1;
    tick();
    chk("jump_1", pc, 12'h010);
    jump_en = 1'b0;
    tick(); tick();
    chk("pc_12", pc, 12'h012);
    stall = 1'b1; halt = 1'b1;
    tick();
    chk("stall_over_halt_pc", pc, 12'h012);
    chk("stall_over_halt_run", running, 1);
    stall = 1'b0; jump_en = 1'b1;
    tick();
    halt = 1'b0; jump_en = 1'b0;
    chk("halt_ack", ack, 1);
    chk("halt_run", running, 0);
    chk("halt_tmo", timeout, 0);
    chk("halt_pc", pc, 12'h012);
    chk("halt_cnt", cycle_cnt, 5);
    tick(); tick();
    chk("done_pc", pc, 12'h012);
    chk("done_cnt", cycle_cnt, 5);
    chk("done_ack", ack, 1);
    start();
    chk("rerun_ack", ack, 0);
    chk("rerun_pc", pc, 0);
    chk("rerun_run", running, 1);

    // Stalls before edges 3, 4 and 15; the last coincides with the budget edge.
    for (int i = 0; i < 16; i++) begin
      stall = (i == 3 || i == 4 || i == 15);
      tick();
    end
    stall = 1'b0;
    chk("tmo_ack", ack, 1);
    chk("tmo_flag", timeout, 1);
    chk("tmo_run", running, 0);
    chk("tmo_pc", pc, 12'h00D);
    chk("tmo_cnt", cycle_cnt, 16);
    start();
    chk("tmo_clr", timeout, 0);
    chk("tmo_ack_clr", ack, 0);
    chk("tmo_rerun", running, 1);

    tick(); tick(); tick();
    chk("pre_arst_pc", pc, 12'h003);
    #2 init_n = 1'b0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_run", running, 0);
    chk("arst_ack", ack, 0);
    chk("arst_cnt", cycle_cnt, 0);
    init_n = 1'b1;
    tick();
    start();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt2_ack", ack, 1);
    #2 init_n = 1'b0;
    #1;
    chk("arst_done_ack", ack, 0);
    chk("arst_done_tmo", timeout, 0);
    init_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
